arbitro_rr_transaccion: RTL and testbench

//  Round-robin scheduler between the 4 input FIFOs and the 4 output FIFOs of the transaction layer.

---
 rtl/arbitro_rr_transaccion.sv | 169 ++++++++++++++++
 tb/tb_arbitro_rr_transaccion.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_rr_transaccion.sv
// Round-robin burst scheduler moving words from the 4 FIFO-in heads to the 4 FIFO-out
// queues selected by each word's destination field, with almost_full backpressure.
module arbitro_rr_transaccion #(
    parameter int FIFO_WORD_SIZE = 10,
    parameter int MAX_BURST      = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      active,
    input  logic [3:0]                fifo_in_empty,
    input  logic [FIFO_WORD_SIZE-1:0] fifo_in_data0,
    input  logic [FIFO_WORD_SIZE-1:0] fifo_in_data1,
    input  logic [FIFO_WORD_SIZE-1:0] fifo_in_data2,
    input  logic [FIFO_WORD_SIZE-1:0] fifo_in_data3,
    input  logic [3:0]                fifo_out_almost_full,
    output logic [3:0]                pop_in,
    output logic [3:0]                push_out,
    output logic [FIFO_WORD_SIZE-1:0] data_out,
    output logic [1:0]                grant_idx,
    output logic                      arb_idle
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_BURST  = 1'b1;
    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    logic [0:0]                state_q, state_d;
    logic [1:0]                rr_ptr_q, rr_ptr_d;
    logic [1:0]                grant_q, grant_d;
    logic [3:0]                burst_cnt_q, burst_cnt_d;
    logic [3:0]                push_q, push_d;
    logic [FIFO_WORD_SIZE-1:0] data_q, data_d;
    logic                      arb_idle_q, arb_idle_d;

    logic [FIFO_WORD_SIZE-1:0] head_s [4];
    logic [3:0]                elig_s;
    logic                      pop_v_s;
    logic [1:0]                pop_idx_s;
    logic [2:0]                pick_s;
    logic [FIFO_WORD_SIZE-1:0] pop_word_s;

    function automatic logic [1:0] dest_of(input logic [FIFO_WORD_SIZE-1:0] word);
        return word[FIFO_WORD_SIZE-1 -: 2];
    endfunction

    // Returns {found, index} of the first request at or after start, wrapping mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!res[2] && req[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign head_s[0] = fifo_in_data0;
    assign head_s[1] = fifo_in_data1;
    assign head_s[2] = fifo_in_data2;
    assign head_s[3] = fifo_in_data3;

    // Per-input eligibility: enabled, has a word, and its target queue has room.
    always_comb begin
        elig_s = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            elig_s[i] = active & ~fifo_in_empty[i] & ~fifo_out_almost_full[dest_of(head_s[i])];
        end
    end

    // Grant/burst state machine; searching from grant+1 puts the old grant last,
    // so it only wins again when it is the sole eligible input.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        burst_cnt_d = burst_cnt_q;
        pop_v_s     = 1'b0;
        pop_idx_s   = grant_q;
        pick_s      = 3'b000;
        case (state_q)
            ST_IDLE: begin
                pick_s = rr_pick(elig_s, rr_ptr_q);
                if (pick_s[2]) begin
                    pop_v_s     = 1'b1;
                    pop_idx_s   = pick_s[1:0];
                    grant_d     = pick_s[1:0];
                    burst_cnt_d = 4'd1;
                    state_d     = ST_BURST;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (elig_s[grant_q] && (burst_cnt_q < BURST_MAX)) begin
                    pop_v_s     = 1'b1;
                    pop_idx_s   = grant_q;
                    burst_cnt_d = burst_cnt_q + 4'd1;
                end else begin
                    rr_ptr_d = grant_q + 2'd1;
                    pick_s   = rr_pick(elig_s, grant_q + 2'd1);
                    if (pick_s[2]) begin
                        pop_v_s     = 1'b1;
                        pop_idx_s   = pick_s[1:0];
                        grant_d     = pick_s[1:0];
                        burst_cnt_d = 4'd1;
                        state_d     = ST_BURST;
                    end else begin
                        burst_cnt_d = 4'd0;
                        state_d     = ST_IDLE;
                    end
                end
            end
            default: begin
                burst_cnt_d = 4'd0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // Pop strobe and next push/data for the word leaving this cycle.
    always_comb begin
        pop_word_s = head_s[pop_idx_s];
        if (pop_v_s && !reset) begin
            pop_in = 4'b0001 << pop_idx_s;
        end else begin
            pop_in = 4'b0000;
        end
        if (pop_v_s) begin
            push_d = 4'b0001 << dest_of(pop_word_s);
            data_d = pop_word_s;
        end else begin
            push_d = 4'b0000;
            data_d = data_q;
        end
        arb_idle_d = (state_d == ST_IDLE) && (&fifo_in_empty) && !pop_v_s;
    end

    // State and output registers; reset drops any word in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= 2'd0;
            grant_q     <= 2'd0;
            burst_cnt_q <= 4'd0;
            push_q      <= 4'b0000;
            data_q      <= {FIFO_WORD_SIZE{1'b0}};
            arb_idle_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            burst_cnt_q <= burst_cnt_d;
            push_q      <= push_d;
            data_q      <= data_d;
            arb_idle_q  <= arb_idle_d;
        end
    end

    assign push_out  = push_q;
    assign data_out  = data_q;
    assign grant_idx = grant_q;
    assign arb_idle  = arb_idle_q;

endmodule

// File: tb/tb_arbitro_rr_transaccion.sv
// Directed scenarios plus randomized traffic for arbitro_rr_transaccion, checked against
// a queue-based reference model of the round-robin burst rules.
module tb_arbitro_rr_transaccion;

    localparam int W  = 10;
    localparam int MB = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         active = 1'b0;
    logic [3:0]   fifo_in_empty = 4'hF;
    logic [W-1:0] d0 = 10'd0;
    logic [W-1:0] d1 = 10'd0;
    logic [W-1:0] d2 = 10'd0;
    logic [W-1:0] d3 = 10'd0;
    logic [3:0]   af = 4'h0;
    logic [3:0]   pop_in;
    logic [3:0]   push_out;
    logic [W-1:0] data_out;
    logic [1:0]   grant_idx;
    logic         arb_idle;

    arbitro_rr_transaccion #(.FIFO_WORD_SIZE(W), .MAX_BURST(MB)) dut (
        .clk                  (clk),
        .reset                (reset),
        .active               (active),
        .fifo_in_empty        (fifo_in_empty),
        .fifo_in_data0        (d0),
        .fifo_in_data1        (d1),
        .fifo_in_data2        (d2),
        .fifo_in_data3        (d3),
        .fifo_out_almost_full (af),
        .pop_in               (pop_in),
        .push_out             (push_out),
        .data_out             (data_out),
        .grant_idx            (grant_idx),
        .arb_idle             (arb_idle)
    );

    always #5 clk = ~clk;

    logic [W-1:0] fq [4][$];
    int           checks = 0;
    int           errors = 0;

    // reference model: current owner (-1 = none), words taken in this run, search start
    int           cur;
    int           run_len;
    int           next_start;
    int           last_grant;
    logic [3:0]   exp_push;
    logic [W-1:0] exp_data;
    logic         exp_idle;

    int           pop_log[$];
    logic         idle_log[$];

    int t1_exp[5] = '{0, 0, 0, -1, -1};
    int t2_exp[8] = '{0, 0, 0, 0, 1, 1, 0, 0};
    int t4_exp[5] = '{2, -1, -1, 0, -1};
    int t5_exp[4] = '{0, 0, -1, -1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] head_of(input int i);
        if (fq[i].size() == 0) return {W{1'b0}};
        return fq[i][0];
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < 4; i++) fifo_in_empty[i] = (fq[i].size() == 0);
        d0 = head_of(0);
        d1 = head_of(1);
        d2 = head_of(2);
        d3 = head_of(3);
    endtask

    task automatic model_reset();
        cur        = -1;
        run_len    = 0;
        next_start = 0;
        last_grant = 0;
        exp_push   = 4'b0000;
        exp_data   = {W{1'b0}};
        exp_idle   = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_pop_in", 32'(pop_in), 32'd0);
        chk("rst_push_out", 32'(push_out), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_grant_idx", 32'(grant_idx), 32'd0);
        chk("rst_arb_idle", 32'(arb_idle), 32'd1);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock: predict the pop from the model, check it, clock, check the registered outputs.
    task automatic run_cycle();
        int           want;
        int           idx;
        int           got;
        bit           e [4];
        bit           all_empty;
        logic [W-1:0] w;
        drive_inputs();
        #1;
        all_empty = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e[i] = 1'b0;
            if (fq[i].size() > 0) begin
                all_empty = 1'b0;
                w = fq[i][0];
                e[i] = active && !af[w[W-1 -: 2]];
            end
        end
        if (cur >= 0 && e[cur] && run_len < MB) begin
            want = cur;
            run_len++;
        end else begin
            if (cur >= 0) next_start = (cur + 1) % 4;
            want = -1;
            for (int k = 0; k < 4; k++) begin
                idx = (next_start + k) % 4;
                if (want < 0 && e[idx]) want = idx;
            end
            cur     = want;
            run_len = (want >= 0) ? 1 : 0;
        end
        chk("pop_in", 32'(pop_in), (want >= 0) ? (32'd1 << want) : 32'd0);
        chk("pop_onehot", 32'($countones(pop_in) <= 1), 32'd1);
        chk("pop_empty", 32'(pop_in & fifo_in_empty), 32'd0);
        got = -1;
        for (int i = 0; i < 4; i++) if (pop_in[i]) got = i;
        pop_log.push_back(got);
        if (want >= 0) begin
            w          = fq[want][0];
            exp_push   = 4'b0001 << w[W-1 -: 2];
            exp_data   = w;
            last_grant = want;
        end else begin
            exp_push   = 4'b0000;
        end
        exp_idle = (want < 0) && all_empty;
        @(posedge clk);
        #1;
        chk("push_out", 32'(push_out), 32'(exp_push));
        chk("data_out", 32'(data_out), 32'(exp_data));
        chk("grant_idx", 32'(grant_idx), 32'(last_grant));
        chk("arb_idle", 32'(arb_idle), 32'(exp_idle));
        idle_log.push_back(arb_idle);
        if (want >= 0) void'(fq[want].pop_front());
    endtask

    task automatic clear_logs();
        pop_log.delete();
        idle_log.delete();
    endtask

    initial begin
        int t3_exp;
        model_reset();
        #1;
        do_reset();

        // T1: three words from FIFO-in0 routed to three different outputs
        active = 1'b1;
        fq[0].push_back(10'h0A6);
        fq[0].push_back(10'h15B);
        fq[0].push_back(10'h2CC);
        clear_logs();
        repeat (5) run_cycle();
        for (int k = 0; k < 5; k++) chk($sformatf("t1_pop%0d", k), 32'(pop_log[k]), 32'(t1_exp[k]));
        chk("t1_idle_busy", 32'(idle_log[2]), 32'd0);
        chk("t1_idle_after", 32'(idle_log[3]), 32'd1);

        // T2: burst limit hands over to FIFO-in1, then back to FIFO-in0
        do_reset();
        for (int k = 0; k < 6; k++) fq[0].push_back(10'h300 + 10'(k));
        fq[1].push_back(10'h011);
        fq[1].push_back(10'h022);
        clear_logs();
        repeat (8) run_cycle();
        for (int k = 0; k < 8; k++) chk($sformatf("t2_pop%0d", k), 32'(pop_log[k]), 32'(t2_exp[k]));

        // T3: full rotation and wrap back to FIFO-in0
        do_reset();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 5; k++) fq[i].push_back({2'(i), 8'(k * 16 + i)});
        clear_logs();
        repeat (20) run_cycle();
        for (int k = 0; k < 20; k++) begin
            t3_exp = (k < 16) ? (k / 4) : (k - 16);
            chk($sformatf("t3_pop%0d", k), 32'(pop_log[k]), 32'(t3_exp));
        end

        // T4: almost_full holds FIFO-in0 back until it drops
        do_reset();
        af = 4'b0010;
        fq[0].push_back(10'h105);
        fq[2].push_back(10'h207);
        clear_logs();
        repeat (3) run_cycle();
        af = 4'b0000;
        repeat (2) run_cycle();
        for (int k = 0; k < 5; k++) chk($sformatf("t4_pop%0d", k), 32'(pop_log[k]), 32'(t4_exp[k]));

        // T5: active drops mid-burst, in-flight push still lands
        do_reset();
        for (int k = 0; k < 4; k++) fq[0].push_back(10'h140 + 10'(k));
        clear_logs();
        repeat (2) run_cycle();
        active = 1'b0;
        repeat (2) run_cycle();
        for (int k = 0; k < 4; k++) chk($sformatf("t5_pop%0d", k), 32'(pop_log[k]), 32'(t5_exp[k]));
        active = 1'b1;
        repeat (3) run_cycle();
        chk("t5_resume", 32'(pop_log[4]), 32'd0);

        // T6: reset between a pop and its push drops the word
        do_reset();
        fq[0].push_back(10'h3AA);
        fq[1].push_back(10'h055);
        fq[2].push_back(10'h2F0);
        clear_logs();
        run_cycle();
        do_reset();
        clear_logs();
        run_cycle();
        chk("t6_first_grant", 32'(pop_log[0]), 32'd1);

        // randomized traffic with occasional resets
        do_reset();
        for (int n = 0; n < 600; n++) begin
            active = ($urandom_range(0, 9) != 0);
            af     = 4'($urandom) & 4'($urandom);
            for (int i = 0; i < 4; i++)
                if (fq[i].size() < 6 && $urandom_range(0, 2) == 0) fq[i].push_back(10'($urandom));
            if (n % 250 == 249) do_reset();
            run_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
